// File: rtl/ascon_perm_engine.sv
// ascon_perm_engine: Ascon p^a/p^b permutation with rate XOR before the first round and key XOR after the last.
// Latency: ceil(R/UNROLL) clocks from the accepted start to done_o and state_o.
// Backpressure: ready_o is low while running; start_i is accepted only when ready_o=1, including the done_o cycle.
// Optional build macro ASCON_PERM_TAG_EN registers the final x3||x4 on tag_o; otherwise tag_o is tied to zero.
module ascon_perm_engine #(
  parameter int UNROLL    = 1,
  parameter int RATE_BITS = 64
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [3:0]           rounds_i,
  input  logic                 load_i,
  input  logic [319:0]         state_i,
  input  logic                 xor_up_en_i,
  input  logic [RATE_BITS-1:0] data_xor_up_i,
  input  logic                 xor_down_en_i,
  input  logic [255:0]         data_xor_down_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [319:0]         state_o,
  output logic [RATE_BITS-1:0] cipher_o,
  output logic [3:0]           round_o,
  output logic [127:0]         tag_o
);

  typedef enum logic {IDLE, RUN} fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [319:0]         state_q, state_d;
  logic [319:0]         src_q, src_d;
  logic [RATE_BITS-1:0] cipher_q, cipher_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic                 up_en_q, up_en_d;
  logic                 down_en_q, down_en_d;
  logic [RATE_BITS-1:0] up_dat_q, up_dat_d;
  logic [255:0]         down_dat_q, down_dat_d;
  logic                 done_q, done_d;

  logic [319:0]         src_sel;
  logic [319:0]         dp_acc;
  logic [4:0]           cnt_sum;
  logic                 last_rnd;
  logic [3:0]           cnt_nxt;

  // Rotate a 64-bit lane right by a constant amount.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round: constant add on x2, bitsliced 5-bit S-box, per-lane linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    // (15-i) is the bitwise complement of a 4-bit index
    x2 = x2 ^ {56'h0, ~idx, idx};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // First round index for a run; anything other than 8 or 6 runs the full 12 rounds.
  function automatic logic [3:0] start_cnt(input logic [3:0] r);
    case (r)
      4'd8:    return 4'd4;
      4'd6:    return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  assign src_sel  = load_i ? state_i : state_q;
  assign cnt_sum  = {1'b0, cnt_q} + 5'(UNROLL);
  assign last_rnd = (cnt_sum >= 5'd12);
  assign cnt_nxt  = last_rnd ? 4'd12 : cnt_sum[3:0];

  // Datapath: rate XOR on the first cycle, up to UNROLL chained rounds (spare stages pass through), key XOR on the last.
  always_comb begin
    dp_acc = first_q ? src_q : state_q;
    if (first_q && up_en_q) begin
      dp_acc[319 -: RATE_BITS] = dp_acc[319 -: RATE_BITS] ^ up_dat_q;
    end
    for (int k = 0; k < UNROLL; k++) begin
      if (({1'b0, cnt_q} + 5'(k)) < 5'd12) begin
        dp_acc = ascon_round(dp_acc, cnt_q + 4'(k));
      end
    end
    if (last_rnd && down_en_q) begin
      dp_acc[255:0] = dp_acc[255:0] ^ down_dat_q;
    end
  end

  // Next-state: IDLE loads or captures operands on start; RUN advances the round counter until 12.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    src_d      = src_q;
    cipher_d   = cipher_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    up_en_d    = up_en_q;
    down_en_d  = down_en_q;
    up_dat_d   = up_dat_q;
    down_dat_d = down_dat_q;
    done_d     = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          src_d      = src_sel;
          cipher_d   = src_sel[319 -: RATE_BITS] ^ data_xor_up_i;
          cnt_d      = start_cnt(rounds_i);
          first_d    = 1'b1;
          up_en_d    = xor_up_en_i;
          down_en_d  = xor_down_en_i;
          up_dat_d   = data_xor_up_i;
          down_dat_d = data_xor_down_i;
          fsm_d      = RUN;
        end else if (load_i) begin
          state_d = state_i;
        end
      end
      RUN: begin
        state_d = dp_acc;
        first_d = 1'b0;
        cnt_d   = cnt_nxt;
        if (last_rnd) begin
          done_d = 1'b1;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State register with synchronous reset that overrides everything, including a run in progress.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      src_q      <= '0;
      cipher_q   <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      up_en_q    <= 1'b0;
      down_en_q  <= 1'b0;
      up_dat_q   <= '0;
      down_dat_q <= '0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      src_q      <= src_d;
      cipher_q   <= cipher_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      up_en_q    <= up_en_d;
      down_en_q  <= down_en_d;
      up_dat_q   <= up_dat_d;
      down_dat_q <= down_dat_d;
      done_q     <= done_d;
    end
  end

`ifdef ASCON_PERM_TAG_EN
  logic [127:0] tag_q;

  // Tag capture: x3||x4 of the final state, after the key XOR.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tag_q <= '0;
    end else if (fsm_q == RUN && last_rnd) begin
      tag_q <= dp_acc[127:0];
    end
  end

  assign tag_o = tag_q;
`else
  assign tag_o = 128'h0;
`endif

  assign ready_o  = (fsm_q == IDLE);
  assign done_o   = done_q;
  assign state_o  = state_q;
  assign cipher_o = cipher_q;
  assign round_o  = (fsm_q == RUN) ? cnt_q : 4'd0;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb_ascon_perm_engine: directed checks of three engine builds (UNROLL 1/4/3, RATE 64/64/128).
// Expected states come from a table-driven reference permutation; cipher and first-round values are hand constants.
// Every comparison goes through chk; one summary line at the end.
module tb_ascon_perm_engine;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  // Zero state after the single round with index 6 (constant 0x96), worked by hand.
  localparam logic [319:0] HAND_R6 = {64'h0012C96000000096, 64'h000000012C000426,
                                      64'hA7FFFFFFFFFFFF20, 64'h25CB000000000096,
                                      64'h0000000000000000};
  localparam logic [255:0] KEY  = {4{64'h0123456789ABCDEF}};
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] UPV  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [319:0] VA   = {5{64'h0F1E2D3C4B5A6978}};
  localparam logic [319:0] VB   = {10{32'h13579BDF}};
  localparam logic [319:0] VC   = {5{64'hFEDCBA9876543210}} ^ 320'h5;
  localparam logic [319:0] VD   = {20{16'hA5C3}};
  localparam logic [319:0] POKE = {10{32'hDEADBEEF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0]       start;
  logic [3:0]       rounds;
  logic             load;
  logic [319:0]     st_in;
  logic             up_en;
  logic [127:0]     up_dat;
  logic             dn_en;
  logic [255:0]     dn_dat;

  logic [2:0]        ready_v, done_v;
  logic [2:0][319:0] state_v;
  logic [2:0][127:0] cipher_v;
  logic [2:0][3:0]   round_v;
  logic [2:0][127:0] tag_v;
  logic [63:0]       cip0, cip1;

  logic [319:0] shadow [3];
  int n_vec = 0;
  int n_err = 0;

  ascon_perm_engine #(.UNROLL(1), .RATE_BITS(64)) u_dut0 (
    .clock_i(clk), .reset_i(rst), .start_i(start[0]), .rounds_i(rounds), .load_i(load),
    .state_i(st_in), .xor_up_en_i(up_en), .data_xor_up_i(up_dat[127:64]),
    .xor_down_en_i(dn_en), .data_xor_down_i(dn_dat), .ready_o(ready_v[0]), .done_o(done_v[0]),
    .state_o(state_v[0]), .cipher_o(cip0), .round_o(round_v[0]), .tag_o(tag_v[0]));

  ascon_perm_engine #(.UNROLL(4), .RATE_BITS(64)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start[1]), .rounds_i(rounds), .load_i(load),
    .state_i(st_in), .xor_up_en_i(up_en), .data_xor_up_i(up_dat[127:64]),
    .xor_down_en_i(dn_en), .data_xor_down_i(dn_dat), .ready_o(ready_v[1]), .done_o(done_v[1]),
    .state_o(state_v[1]), .cipher_o(cip1), .round_o(round_v[1]), .tag_o(tag_v[1]));

  ascon_perm_engine #(.UNROLL(3), .RATE_BITS(128)) u_dut2 (
    .clock_i(clk), .reset_i(rst), .start_i(start[2]), .rounds_i(rounds), .load_i(load),
    .state_i(st_in), .xor_up_en_i(up_en), .data_xor_up_i(up_dat),
    .xor_down_en_i(dn_en), .data_xor_down_i(dn_dat), .ready_o(ready_v[2]), .done_o(done_v[2]),
    .state_o(state_v[2]), .cipher_o(cipher_v[2]), .round_o(round_v[2]), .tag_o(tag_v[2]));

  assign cipher_v[0] = {cip0, 64'h0};
  assign cipher_v[1] = {cip1, 64'h0};

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference round: table S-box per column (x0 is the MSB), bit-indexed rotations.
  function automatic logic [319:0] m_round(input logic [319:0] s, input int i);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [63:0] z [5];
    logic [4:0]  col, o;
    logic [319:0] res;
    int r1, r2;
    for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'(((15 - i) << 4) | i);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = SBOX[col];
      y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
    end
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin r1 = 19; r2 = 28; end
        1: begin r1 = 61; r2 = 39; end
        2: begin r1 = 1;  r2 = 6;  end
        3: begin r1 = 10; r2 = 17; end
        default: begin r1 = 7; r2 = 41; end
      endcase
      for (int j = 0; j < 64; j++) z[k][j] = y[k][j] ^ y[k][(j + r1) % 64] ^ y[k][(j + r2) % 64];
    end
    for (int k = 0; k < 5; k++) res[319-64*k -: 64] = z[k];
    return res;
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] src, input logic ue, input logic [127:0] up,
                                          input int rate, input logic de, input logic [255:0] dn,
                                          input logic [3:0] r);
    logic [319:0] s;
    int nr;
    s = src;
    if (ue) begin
      if (rate == 128) s[319:192] = s[319:192] ^ up;
      else             s[319:256] = s[319:256] ^ up[127:64];
    end
    nr = (r == 4'd8) ? 8 : (r == 4'd6) ? 6 : 12;
    for (int i = 12 - nr; i < 12; i++) s = m_round(s, i);
    if (de) s[255:0] = s[255:0] ^ dn;
    return s;
  endfunction

  // Start a run on engine d, optionally poking start/load mid-run, then check latency, cipher, state and tag.
  task automatic do_run(input int d, input logic [3:0] r, input logic ld, input logic [319:0] st,
                        input logic ue, input logic [127:0] up, input logic de, input logic [255:0] dn,
                        input int exp_lat, input bit poke, input string tag);
    logic [319:0] src, expv;
    logic [127:0] expc;
    int rate, lat;
    bit got;
    rate = (d == 2) ? 128 : 64;
    src  = ld ? st : shadow[d];
    expv = m_perm(src, ue, up, rate, de, dn, r);
    expc = (rate == 128) ? (src[319:192] ^ up) : {src[319:256] ^ up[127:64], 64'h0};
    chk($sformatf("%s_rdy", tag), ready_v[d], 1);
    rounds = r; load = ld; st_in = st; up_en = ue; up_dat = up; dn_en = de; dn_dat = dn;
    start[d] = 1'b1;
    @(posedge clk); #1;
    if (ld) for (int o = 0; o < 3; o++) if (o != d) shadow[o] = st;
    // scramble the start-sampled inputs so only the captured copies can be used
    start[d] = 1'b0; load = 1'b0; rounds = 4'd6; up_en = ~ue; up_dat = ~up; dn_en = ~de; dn_dat = ~dn;
    chk($sformatf("%s_busy", tag), ready_v[d], 0);
    chk($sformatf("%s_cipher", tag), cipher_v[d], expc);
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (poke && c == 2) begin
        start[d] = 1'b1; load = 1'b1; st_in = POKE;
      end
      @(posedge clk); #1;
      if (start[d] || load) begin
        for (int o = 0; o < 3; o++) if (o != d) shadow[o] = POKE;
      end
      start[d] = 1'b0; load = 1'b0;
      if (done_v[d]) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk($sformatf("%s_lat", tag), lat, exp_lat);
    chk($sformatf("%s_state", tag), state_v[d], expv);
`ifdef ASCON_PERM_TAG_EN
    chk($sformatf("%s_tag", tag), tag_v[d], expv[127:0]);
`else
    chk($sformatf("%s_tag", tag), tag_v[d], 128'h0);
`endif
    shadow[d] = expv;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    rst = 1'b1; start = '0; rounds = '0; load = 1'b0; st_in = '0;
    up_en = 1'b0; up_dat = '0; dn_en = 1'b0; dn_dat = '0;
    for (int d = 0; d < 3; d++) shadow[d] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_ready", d), ready_v[d], 1);
      chk($sformatf("rst%0d_done", d), done_v[d], 0);
      chk($sformatf("rst%0d_state", d), state_v[d], '0);
      chk($sformatf("rst%0d_round", d), round_v[d], 0);
      chk($sformatf("rst%0d_cipher", d), cipher_v[d], '0);
      chk($sformatf("rst%0d_tag", d), tag_v[d], '0);
    end

    // IDLE load without start
    load = 1'b1; st_in = VA;
    @(posedge clk); #1;
    load = 1'b0;
    chk("load_only", state_v[0], VA);
    for (int d = 0; d < 3; d++) shadow[d] = VA;

    // Round indices and first constant: p6 of the zero state
    load = 1'b1; st_in = '0; rounds = 4'd6; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0; load = 1'b0;
    chk("rt_idx0", round_v[0], 6);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("rt_k96_state", state_v[0], HAND_R6);
      if (c < 6) begin
        chk($sformatf("rt_idx%0d", c), round_v[0], 6 + c);
        chk($sformatf("rt_nodone%0d", c), done_v[0], 0);
      end else begin
        chk("rt_done", done_v[0], 1);
        chk("rt_p6", state_v[0], m_perm('0, 1'b0, '0, 64, 1'b0, '0, 4'd6));
        chk("rt_idle_round", round_v[0], 0);
      end
    end
    @(posedge clk); #1;
    chk("rt_done_pulse", done_v[0], 0);
    shadow[0] = m_perm('0, 1'b0, '0, 64, 1'b0, '0, 4'd6);
    shadow[1] = '0;
    shadow[2] = '0;

    // Reset in the middle of a 12-round run
    load = 1'b1; st_in = VA; rounds = 4'd12; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0; load = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_ready", ready_v[0], 1);
    chk("mr_state", state_v[0], '0);
    chk("mr_round", round_v[0], 0);
    chk("mr_cipher", cipher_v[0], '0);
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      if (done_v[0]) ndone++;
      @(posedge clk); #1;
    end
    chk("mr_no_done", ndone, 0);
    for (int d = 0; d < 3; d++) shadow[d] = '0;

    // Unroll remainder handling
    do_run(0, 4'd6,  1'b1, VB, 1'b0, '0,  1'b0, '0,  6, 1'b0, "u1_r6");
    do_run(1, 4'd6,  1'b1, VB, 1'b0, '0,  1'b0, '0,  2, 1'b0, "u4_r6");
    do_run(1, 4'd8,  1'b1, VC, 1'b1, UPV, 1'b0, '0,  2, 1'b0, "u4_r8");
    do_run(1, 4'd12, 1'b1, VD, 1'b1, UPV, 1'b1, KEY, 3, 1'b0, "u4_r12");
    do_run(2, 4'd6,  1'b1, VB, 1'b0, '0,  1'b0, '0,  2, 1'b0, "u3_r6");

    // Full run with both XORs on the 128-bit rate, then a zero-bubble second start
    do_run(2, 4'd12, 1'b1, 320'h1, 1'b1, ONES, 1'b1, KEY, 4, 1'b0, "full");
    chk("full_cipher_hand", cipher_v[2], ONES);
    do_run(2, 4'd8, 1'b0, '0, 1'b0, '0, 1'b0, '0, 3, 1'b0, "b2b");

    // Ignored start/load during RUN and an illegal round count
    do_run(0, 4'd5, 1'b1, VC, 1'b1, UPV, 1'b1, KEY, 12, 1'b1, "illegal");
    @(posedge clk); #1;
    chk("ill_done_pulse", done_v[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
